spi_sram_responder: RTL
=======================

SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning memory depth is 2^ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on spi_ss_n, spi_sck and spi_mosi.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port spi_ss_n, input, 1 bit: chip select, active-low, asynchronous to clk_i.
REQ-006 The block SHALL have port spi_sck, input, 1 bit: SPI clock, mode 0, with f(spi_sck) <= f(clk_i)/8.
REQ-007 The block SHALL have port spi_mosi, input, 1 bit: serial data in, MSB first.
REQ-008 The block SHALL have port spi_miso, output, 1 bit: serial data out, MSB first.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a frame is active (synchronized spi_ss_n is low).

Function
REQ-010 The block SHALL act as a serial-SRAM responder, the far end of the team's SPI SRAM controller, with opcodes 0x03 READ, 0x02 WRITE, 0x05 RDMR and 0x01 WRMR.
REQ-011 The block SHALL sample spi_mosi one clk_i cycle after a synchronized rising spi_sck edge, and SHALL update spi_miso one clk_i cycle after a synchronized falling spi_sck edge.
REQ-012 The block SHALL use FSM states IDLE, CMD, ADDR, DATA_RD, DATA_WR, MODE_RD, MODE_WR and IGNORE.
REQ-013 On the falling edge of synchronized spi_ss_n, the FSM SHALL move IDLE->CMD and clear the bit counter.
REQ-014 After 8 CMD bits, the FSM SHALL go to ADDR for READ/WRITE, MODE_RD for RDMR, MODE_WR for WRMR, and IGNORE for any other opcode.
REQ-015 After 24 ADDR bits, the FSM SHALL go to DATA_RD or DATA_WR; address bits above ADDR_WIDTH-1 SHALL be ignored.
REQ-016 The first READ data bit SHALL appear on spi_miso at the falling spi_sck edge that follows the 32nd rising edge.
REQ-017 READ SHALL fetch mem[addr] when the last address bit is sampled.
REQ-018 A WRITE byte SHALL be committed to mem[addr] in the clk_i cycle after its 8th bit is sampled.
REQ-019 In sequential mode, the address SHALL increment after each byte and wrap from 2^ADDR_WIDTH-1 to 0.
REQ-020 A READ of an address SHALL return the byte written to it, including a byte written earlier in the same burst.
REQ-021 spi_miso SHALL be 0 in IDLE, CMD, ADDR, DATA_WR, MODE_WR and IGNORE.
REQ-022 If spi_ss_n rises in any state, the FSM SHALL return to IDLE within SYNC_STAGES+1 cycles and SHALL discard any partial write byte; completed bytes SHALL be retained.
REQ-023 Any spi_sck edge seen while spi_ss_n is high SHALL be ignored.
REQ-024 If a spi_ss_n rise and an spi_sck edge are detected in the same cycle, the spi_ss_n rise SHALL win.

Reset
REQ-025 While rst_ni is low, the block SHALL hold FSM=IDLE, spi_miso=0, busy_o=0, bit counter=0, synchronizers=1 (ss_n) and 0 (sck, mosi), and mode register=0x40 (sequential).
REQ-026 Reset SHALL NOT initialize memory contents.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after reset is released, the next falling spi_ss_n edge SHALL start a fresh frame.

Configuration
REQ-028 With SPI_SRAM_MODE_REG_EN defined, RDMR SHALL return the mode register and WRMR SHALL load it.
REQ-029 With SPI_SRAM_MODE_REG_EN defined, mode bits[7:6]=00 SHALL select byte mode (no address increment; bytes after the first SHALL repeat the same address) and 01 SHALL select sequential mode; other encodings SHALL behave as sequential.
REQ-030 Without SPI_SRAM_MODE_REG_EN, the block SHALL be fixed in sequential mode, SHALL treat RDMR/WRMR as unknown opcodes (IGNORE), and SHALL NOT contain the mode register.

Structure
REQ-031 Opcode constants, mode encodings and the FSM state enum SHALL reside in shared package spi_sram_pkg.
REQ-032 Synchronization and edge detection SHALL be one sub-module, spi_sync_edge, instantiated once per SPI input (ss_n with rise/fall outputs, sck with rise/fall outputs).

Verification
REQ-033 Bench SHALL cover: WRITE 0x02, addr 0x000010, data 0xA5 0x5A, then READ 0x03 addr 0x000010 of 2 bytes -> spi_miso returns 0xA5 then 0x5A.
REQ-034 Bench SHALL cover: WRITE at addr 0x0003FF with 0x11 0x22, ADDR_WIDTH=10 -> mem[0x3FF]=0x11, mem[0x000]=0x22 (wrap).
REQ-035 Bench SHALL cover: WRITE addr 0x20 data 0xFF, then spi_ss_n high after 4 bits of a second byte -> mem[0x20]=0xFF, mem[0x21] unchanged.
REQ-036 Bench SHALL cover: opcode 0x9F followed by 32 clocks -> spi_miso stays 0, memory unchanged, busy_o falls after spi_ss_n rises.
REQ-037 Bench SHALL cover, with SPI_SRAM_MODE_REG_EN: WRMR 0x00 then READ addr 0x10 for 3 bytes -> spi_miso returns mem[0x10] three times; RDMR -> 0x00.
REQ-038 Bench SHALL cover: rst_ni pulsed low mid-ADDR -> spi_miso=0 and busy_o=0 immediately; the next frame READ addr 0x10 -> correct data.

Source files
------------

// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
// spi_sram_pkg : opcodes, mode encodings and FSM states for spi_sram_responder
// Revision     : 1.0
// ============================================================================
package spi_sram_pkg;

  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDMR  = 8'h05;

  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_SEQ   = 2'b01;
  localparam logic [7:0] MODE_RESET = {MODE_SEQ, 6'b00_0000};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    DATA_RD = 3'd3,
    DATA_WR = 3'd4,
    MODE_RD = 3'd5,
    MODE_WR = 3'd6,
    IGNORE  = 3'd7
  } state_e;

  // Only the byte-mode encoding stops the address; everything else is sequential.
  function automatic logic mode_is_seq(input logic [1:0] mode_bits);
    return mode_bits != MODE_BYTE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// spi_sync_edge : multi-flop synchronizer with rise/fall detection on the
//                 synchronized level.
// Revision      : 1.0
// ============================================================================
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_sram_responder.sv
`default_nettype none
// ============================================================================
// spi_sram_responder : SPI mode-0 serial-SRAM responder (READ/WRITE, optional
//                      RDMR/WRMR mode register when SPI_SRAM_MODE_REG_EN is set)
// Revision           : 1.0
// ============================================================================
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic spi_ss_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic ss_s, ss_rise, ss_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (spi_ss_n),
    .q_o (ss_s), .rise_o (ss_rise), .fall_o (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (spi_sck),
    .q_o (sck_s), .rise_o (sck_rise), .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (spi_mosi),
    .q_o (mosi_s), .rise_o (), .fall_o ()
  );

  state_e                  state_q, state_d;
  logic [4:0]              bitcnt_q, bitcnt_d;
  logic [7:0]              sh_q, sh_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              rd_q, rd_d;
  logic [2:0]              rdcnt_q, rdcnt_d;
  logic                    miso_q, miso_d;
  logic                    is_rd_q, is_rd_d;
  logic                    wr_pend_q, wr_pend_d;
  logic [7:0]              wr_byte_q, wr_byte_d;
  logic                    sck_rise_q, sck_fall_q;
  logic [7:0]              mem_q [DEPTH];

  logic                    seq;
  logic                    bit_in, bit_out;
  logic [7:0]              sh_next;
  logic [ADDR_WIDTH-1:0]   addr_shift, addr_adv, rd_addr;
  logic [7:0]              rd_data;

`ifdef SPI_SRAM_MODE_REG_EN
  logic [7:0] mode_q, mode_d;
  assign seq = mode_is_seq(mode_q[7:6]);
`else
  assign seq = 1'b1;
`endif

  // Edges act one clk_i after detection; clock edges outside a frame are dropped.
  assign bit_in     = sck_rise_q & ~ss_s;
  assign bit_out    = sck_fall_q & ~ss_s;
  assign sh_next    = {sh_q[6:0], mosi_s};
  assign addr_shift = {addr_q[ADDR_WIDTH-2:0], mosi_s};
  assign addr_adv   = seq ? addr_q + 1'b1 : addr_q;
  assign rd_addr    = (state_q == ADDR) ? addr_shift : addr_adv;
  assign rd_data    = mem_q[rd_addr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      rdcnt_q    <= '0;
      miso_q     <= 1'b0;
      is_rd_q    <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_byte_q  <= '0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
`ifdef SPI_SRAM_MODE_REG_EN
      mode_q     <= MODE_RESET;
`endif
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      rdcnt_q    <= rdcnt_d;
      miso_q     <= miso_d;
      is_rd_q    <= is_rd_d;
      wr_pend_q  <= wr_pend_d;
      wr_byte_q  <= wr_byte_d;
      sck_rise_q <= sck_rise;
      sck_fall_q <= sck_fall;
`ifdef SPI_SRAM_MODE_REG_EN
      mode_q     <= mode_d;
`endif
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_pend_q) begin
      mem_q[addr_q] <= wr_byte_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    rdcnt_d   = rdcnt_q;
    miso_d    = miso_q;
    is_rd_d   = is_rd_q;
    wr_pend_d = 1'b0;
    wr_byte_d = wr_byte_q;
`ifdef SPI_SRAM_MODE_REG_EN
    mode_d    = mode_q;
`endif

    if (wr_pend_q) begin
      addr_d = addr_adv;
    end

    if (ss_rise) begin
      state_d  = IDLE;
      bitcnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d  = CMD;
            bitcnt_d = '0;
          end
        end
        CMD: begin
          if (bit_in) begin
            sh_d     = sh_next;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              if (sh_next == OP_READ || sh_next == OP_WRITE) begin
                state_d = ADDR;
                is_rd_d = (sh_next == OP_READ);
              end
`ifdef SPI_SRAM_MODE_REG_EN
              else if (sh_next == OP_RDMR) begin
                state_d = MODE_RD;
                rd_d    = mode_q;
                rdcnt_d = '0;
              end else if (sh_next == OP_WRMR) begin
                state_d = MODE_WR;
              end
`endif
              else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          if (bit_in) begin
            addr_d   = addr_shift;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              bitcnt_d = '0;
              if (is_rd_q) begin
                state_d = DATA_RD;
                rd_d    = rd_data;
                rdcnt_d = '0;
              end else begin
                state_d = DATA_WR;
              end
            end
          end
        end
        DATA_WR: begin
          if (bit_in) begin
            sh_d     = sh_next;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d  = '0;
              wr_pend_d = 1'b1;
              wr_byte_d = sh_next;
            end
          end
        end
        DATA_RD: begin
          if (bit_out) begin
            miso_d = rd_q[7];
            if (rdcnt_q == 3'd7) begin
              // Prefetch the next byte as the last bit of this one leaves.
              rdcnt_d = '0;
              addr_d  = addr_adv;
              rd_d    = rd_data;
            end else begin
              rdcnt_d = rdcnt_q + 3'd1;
              rd_d    = {rd_q[6:0], 1'b0};
            end
          end
        end
`ifdef SPI_SRAM_MODE_REG_EN
        MODE_RD: begin
          if (bit_out) begin
            miso_d = rd_q[7];
            if (rdcnt_q == 3'd7) begin
              rdcnt_d = '0;
              rd_d    = mode_q;
            end else begin
              rdcnt_d = rdcnt_q + 3'd1;
              rd_d    = {rd_q[6:0], 1'b0};
            end
          end
        end
        MODE_WR: begin
          if (bit_in) begin
            sh_d     = sh_next;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              mode_d   = sh_next;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end

    if (state_d != DATA_RD && state_d != MODE_RD) begin
      miso_d = 1'b0;
    end
  end

  assign spi_miso = miso_q;
  assign busy_o   = ~ss_s;

  logic unused_sck_level;
  assign unused_sck_level = sck_s;

endmodule
`default_nettype wire
